// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the multiplier-sharing logic.
// Floats are 31-bit unsigned values: exponent [30:23], mantissa [22:0].
package fp_pkg;

  localparam int unsigned FP_W  = 31;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;

  typedef struct packed {
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } float_t;

  // Arbiter FSM: flush the unreset multiplier first, then arbitrate.
  typedef enum logic [0:0] {
    StDrain,
    StRun
  } arb_state_e;

  // Width of a requester index; at least one bit.
  function automatic int unsigned req_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin priority search.
// The search starts at ptr and wraps from NUM_REQ-1 back to 0; the first set
// request bit wins.
// Ports:
//   req   - request vector
//   ptr   - highest-priority requester for this cycle
//   grant - one-hot winner (all zero when nothing requests)
//   idx   - encoded winner (0 when nothing requests)
//   found - any request present
module rr_arbiter
  import fp_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = req_idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               found
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos = IDX_W'((32'(ptr) + i) % NUM_REQ);
      if (!found && req[pos]) begin
        found      = 1'b1;
        grant[pos] = 1'b1;
        idx        = pos;
      end
    end
  end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin sharing of one fixed-latency FP multiplier among NUM_REQ
// requesters. Each issued operation carries its requester index through a tag
// pipe aligned with the multiplier latency, so the result is routed back to
// the requester that issued it.
//
// After reset the block sits in a drain phase for MUL_LATENCY+1 cycles with
// grants suppressed, so stale results from the (unreset) multiplier are never
// returned.
//
// Optional build macro FP_MUL_ARB_CHECK_EN: when defined, err is set (sticky
// until rst) whenever mul_ready disagrees with the tag-pipe head while running.
// When undefined, err is tied low.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   req_valid/a/b       - per-requester request and packed operands (31 bits each)
//   req_grant           - combinational one-hot grant
//   mul_valid/in_1/in_2 - registered operation to the multiplier
//   mul_ready/result    - multiplier result strobe and value
//   resp_valid/data     - registered one-hot result strobe, shared result bus
//   busy                - draining or operations in flight
//   err                 - sticky tag/result mismatch (check build only)
module fp_mul_arbiter
  import fp_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MUL_LATENCY = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic [NUM_REQ-1:0]      req_grant,
  output logic                    mul_valid,
  output logic [FP_W-1:0]         mul_in_1,
  output logic [FP_W-1:0]         mul_in_2,
  input  logic                    mul_ready,
  input  logic [FP_W-1:0]         mul_result,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [FP_W-1:0]         resp_data,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned IDX_W = req_idx_w(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MUL_LATENCY + 1);
  localparam int unsigned INF_W = $clog2(MUL_LATENCY + 2);

  localparam logic [CNT_W-1:0]   DrainLoad = CNT_W'(MUL_LATENCY);
  localparam logic [IDX_W-1:0]   LastIdx   = IDX_W'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] OneHot0   = NUM_REQ'(1);

  // FSM and pointer
  arb_state_e       state_q, state_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  // Arbiter outputs
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_found;
  logic               xfer;

  // Issue stage
  logic             mul_valid_q;
  logic [IDX_W-1:0] mul_idx_q;
  float_t           mul_a_q, mul_b_q;
  float_t           win_a, win_b;

  // Tag pipe: entry MUL_LATENCY-1 lines up with mul_ready
  logic [MUL_LATENCY-1:0] tag_vld_q;
  logic [IDX_W-1:0]       tag_idx_q [MUL_LATENCY];
  logic                   head_vld;
  logic [IDX_W-1:0]       head_idx;

  // Return stage and occupancy
  logic [NUM_REQ-1:0] resp_valid_q;
  logic [FP_W-1:0]    resp_data_q;
  logic [INF_W-1:0]   inflight_q, inflight_d;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .found (arb_found)
  );

  assign req_grant = (state_q == StRun) ? arb_grant : '0;
  assign xfer      = (state_q == StRun) && arb_found;

  // Operand mux for the winning requester.
  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        win_a = req_a[i*FP_W +: FP_W];
        win_b = req_b[i*FP_W +: FP_W];
      end
    end
  end

  // FSM next state: count down the drain window, then run forever.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    unique case (state_q)
      StDrain: begin
        if (drain_cnt_q == '0) begin
          state_d = StRun;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      StRun: begin
        state_d = StRun;
      end
      default: begin
        state_d = StDrain;
      end
    endcase
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (arb_idx == LastIdx) ? '0 : arb_idx + 1'b1;
    end
  end

  assign head_vld = tag_vld_q[MUL_LATENCY-1];
  assign head_idx = tag_idx_q[MUL_LATENCY-1];

  always_comb begin
    inflight_d = inflight_q;
    if (xfer && !head_vld) begin
      inflight_d = inflight_q + INF_W'(1);
    end else if (!xfer && head_vld) begin
      inflight_d = inflight_q - INF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StDrain;
      drain_cnt_q <= DrainLoad;
      rr_ptr_q    <= '0;
      inflight_q  <= '0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      inflight_q  <= inflight_d;
    end
  end

  // Issue register: operands hold when nothing is transferred.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_valid_q <= 1'b0;
      mul_idx_q   <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      mul_valid_q <= xfer;
      if (xfer) begin
        mul_idx_q <= arb_idx;
        mul_a_q   <= win_a;
        mul_b_q   <= win_b;
      end
    end
  end

  // Tag pipe is fed from the issue register so the head lands on mul_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      for (int unsigned i = 0; i < MUL_LATENCY; i++) begin
        tag_idx_q[i] <= '0;
      end
    end else begin
      tag_vld_q[0] <= mul_valid_q;
      tag_idx_q[0] <= mul_idx_q;
      for (int unsigned i = 1; i < MUL_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

  // Return stage: trust the tag head, not mul_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else if (head_vld) begin
      resp_valid_q <= OneHot0 << head_idx;
      resp_data_q  <= mul_result;
    end else begin
      resp_valid_q <= '0;
    end
  end

  assign mul_valid  = mul_valid_q;
  assign mul_in_1   = mul_a_q;
  assign mul_in_2   = mul_b_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q == StDrain) || (inflight_q != '0);

`ifdef FP_MUL_ARB_CHECK_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if ((state_q == StRun) && (mul_ready != head_vld)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  logic unused_mul_ready;
  assign unused_mul_ready = mul_ready;
  assign err              = 1'b0;
`endif

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter (NUM_REQ=4, MUL_LATENCY=3).
// The multiplier model echoes mul_in_1 three cycles after mul_valid and never
// resets, so stale results surface during the drain window.
module tb_fp_mul_arbiter;

  localparam int unsigned NR  = 4;
  localparam int unsigned LAT = 3;
`ifdef FP_MUL_ARB_CHECK_EN
  localparam logic CheckEn = 1'b1;
`else
  localparam logic CheckEn = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*31-1:0] req_a = '0;
  logic [NR*31-1:0] req_b = '0;
  logic [NR-1:0]   req_grant;
  logic            mul_valid;
  logic [30:0]     mul_in_1;
  logic [30:0]     mul_in_2;
  logic            mul_ready;
  logic [30:0]     mul_result;
  logic [NR-1:0]   resp_valid;
  logic [30:0]     resp_data;
  logic            busy;
  logic            err;
  logic            inject = 1'b0;

  fp_mul_arbiter #(
    .NUM_REQ     (NR),
    .MUL_LATENCY (LAT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_grant  (req_grant),
    .mul_valid  (mul_valid),
    .mul_in_1   (mul_in_1),
    .mul_in_2   (mul_in_2),
    .mul_ready  (mul_ready),
    .mul_result (mul_result),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  // Multiplier model: three-stage echo of operand A, no reset.
  logic [2:0]  m_v  = '0;
  logic [30:0] m_d0 = '0;
  logic [30:0] m_d1 = '0;
  logic [30:0] m_d2 = '0;

  always @(posedge clk) begin
    m_v  <= {m_v[1:0], mul_valid};
    m_d0 <= mul_in_1;
    m_d1 <= m_d0;
    m_d2 <= m_d1;
  end

  assign mul_ready  = m_v[2] | inject;
  assign mul_result = m_d2;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_lane(input int i, input logic [30:0] a, input logic [30:0] b);
    req_a[i*31 +: 31] = a;
    req_b[i*31 +: 31] = b;
  endtask

  function automatic logic [30:0] lane_val(input int i);
    return 31'h1234500 + 31'(i * 17);
  endfunction

  logic [3:0]  exp_rv;
  logic [31:0] peak;

  initial begin
    // Reset values
    repeat (3) tick();
    #1;
    check_eq("rst_mul_valid", {31'd0, mul_valid}, 0);
    check_eq("rst_mul_in_1", {1'b0, mul_in_1}, 0);
    check_eq("rst_resp_valid", {28'd0, resp_valid}, 0);
    check_eq("rst_resp_data", {1'b0, resp_data}, 0);
    check_eq("rst_err", {31'd0, err}, 0);
    check_eq("rst_busy", {31'd0, busy}, 1);

    // Drain window: 4 cycles, grants suppressed, spurious mul_ready ignored
    for (int i = 0; i < NR; i++) set_lane(i, lane_val(i), 31'h40000000 + 31'(i));
    req_valid = 4'hF;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      inject = (c == 1);
      #1;
      check_eq("drain_busy", {31'd0, busy}, 1);
      check_eq("drain_grant", {28'd0, req_grant}, 0);
      check_eq("drain_resp", {28'd0, resp_valid}, 0);
      check_eq("drain_err", {31'd0, err}, 0);
      tick();
    end
    inject = 1'b0;
    req_valid = '0;
    #1;
    check_eq("run_busy", {31'd0, busy}, 0);
    check_eq("run_err", {31'd0, err}, 0);

    // All four requesting for 8 cycles: order 0,1,2,3,0,1,2,3
    peak = 0;
    for (int c = 0; c < 15; c++) begin
      req_valid = (c < 8) ? 4'hF : 4'h0;
      #1;
      if (c < 8) check_eq("rr_grant", {28'd0, req_grant}, 32'(1) << (c % 4));
      exp_rv = (c >= 5 && c <= 12) ? (4'b0001 << ((c - 5) % 4)) : 4'b0000;
      check_eq("rr_resp_valid", {28'd0, resp_valid}, {28'd0, exp_rv});
      if (c >= 5 && c <= 12) check_eq("rr_resp_data", {1'b0, resp_data}, {1'b0, lane_val((c - 5) % 4)});
      if (32'(dut.inflight_q) > peak) peak = 32'(dut.inflight_q);
      if (c == 14) check_eq("rr_busy_end", {31'd0, busy}, 0);
      tick();
    end
    check_eq("inflight_peak", peak, 4);

    // Requester 1 drops at its grant edge; 3 waiting gets next; pointer wraps to 0
    req_valid = 4'b1010;
    #1;
    check_eq("drop_grant1", {28'd0, req_grant}, 32'b0010);
    tick();
    req_valid = 4'b1000;
    #1;
    check_eq("drop_grant3", {28'd0, req_grant}, 32'b1000);
    tick();
    req_valid = 4'b1001;
    #1;
    check_eq("wrap_grant0", {28'd0, req_grant}, 32'b0001);
    req_valid = '0;
    for (int c = 2; c < 8; c++) begin
      #1;
      exp_rv = (c == 5) ? 4'b0010 : (c == 6) ? 4'b1000 : 4'b0000;
      check_eq("drop_resp", {28'd0, resp_valid}, {28'd0, exp_rv});
      if (c == 6) check_eq("drop_data", {1'b0, resp_data}, {1'b0, lane_val(3)});
      tick();
    end

    // Single request on lane 2
    set_lane(2, 31'h3F800000, 31'h40000000);
    req_valid = 4'b0100;
    #1;
    check_eq("single_grant", {28'd0, req_grant}, 32'b0100);
    tick();
    req_valid = '0;
    #1;
    check_eq("single_mul_valid", {31'd0, mul_valid}, 1);
    check_eq("single_in_1", {1'b0, mul_in_1}, 32'h3F800000);
    check_eq("single_in_2", {1'b0, mul_in_2}, 32'h40000000);
    check_eq("single_busy", {31'd0, busy}, 1);
    tick();
    for (int c = 2; c < 7; c++) begin
      #1;
      if (c == 2) begin
        check_eq("single_mv_low", {31'd0, mul_valid}, 0);
        check_eq("single_in_hold", {1'b0, mul_in_1}, 32'h3F800000);
      end
      check_eq("single_resp", {28'd0, resp_valid}, (c == 5) ? 32'b0100 : 32'b0);
      if (c == 5) begin
        check_eq("single_data", {1'b0, resp_data}, 32'h3F800000);
        check_eq("single_busy_done", {31'd0, busy}, 0);
      end
      tick();
    end

    // Reset with three operations in flight
    set_lane(0, 31'h2AAAAAA, 31'h1);
    req_valid = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq("mid_grant", {28'd0, req_grant}, 32'b0001);
      tick();
    end
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      check_eq("mid_busy", {31'd0, busy}, (c < 4) ? 32'd1 : 32'd0);
      check_eq("mid_resp", {28'd0, resp_valid}, 0);
      if (c < 4) check_eq("mid_grant_off", {28'd0, req_grant}, 0);
      tick();
    end
    check_eq("mid_err", {31'd0, err}, 0);
    set_lane(1, 31'h5555555, 31'h2);
    req_valid = 4'b0010;
    #1;
    check_eq("post_grant", {28'd0, req_grant}, 32'b0010);
    tick();
    req_valid = '0;
    for (int c = 1; c < 6; c++) begin
      #1;
      check_eq("post_resp", {28'd0, resp_valid}, (c == 5) ? 32'b0010 : 32'b0);
      if (c == 5) check_eq("post_data", {1'b0, resp_data}, 32'h5555555);
      tick();
    end

    // Extra mul_ready pulse while running
    #1;
    check_eq("err_before", {31'd0, err}, 0);
    inject = 1'b1;
    tick();
    inject = 1'b0;
    #1;
    check_eq("err_set", {31'd0, err}, {31'd0, CheckEn});
    check_eq("err_no_resp", {28'd0, resp_valid}, 0);
    tick();
    tick();
    #1;
    check_eq("err_sticky", {31'd0, err}, {31'd0, CheckEn});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check_eq("err_cleared", {31'd0, err}, 0);
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
